// File: rtl/ex_muldiv_ctrl.sv
// ex_muldiv_ctrl: iterative 32-bit multiply/divide sequencer owning HI/LO.
module ex_muldiv_ctrl (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [1:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        HiWrite,
  input  logic        LoWrite,
  input  logic [31:0] WriteData,
  output logic        Stall,
  output logic        Busy,
  output logic        Done,
  output logic        DivByZero,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} stateT;
  stateT state, nextState;
  logic isDiv, negRes, negRem, zeroDiv;
  logic [5:0] count;
  logic [31:0] opB, aHold, absA, absB, quot, rem;
  logic [63:0] acc, prod;
  logic [32:0] mulSum, divShift, divDiff;
  always_ff @(posedge Clk)
    if (Reset) state <= IDLE;
    else state <= nextState;
  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (Start) nextState = (Op[1] && B == 32'd0) ? FIX : RUN;
      RUN: if (count == 6'd31) nextState = FIX;
      FIX: nextState = DONE;
      default: nextState = IDLE;
    endcase
  end
  always_comb begin
    absA = (!Op[0] && A[31]) ? -A : A;
    absB = (!Op[0] && B[31]) ? -B : B;
    mulSum = {1'b0, acc[63:32]} + {1'b0, acc[0] ? opB : 32'd0};
    divShift = acc[63:31];
    divDiff = divShift - {1'b0, opB};
    prod = negRes ? -acc : acc;
    quot = negRes ? -acc[31:0] : acc[31:0];
    rem = negRem ? -acc[63:32] : acc[63:32];
  end
  // acc holds product (mult) or remainder:quotient (div); the low half starts as |A|
  always_ff @(posedge Clk) begin
    if (Reset) begin
      {isDiv, negRes, negRem, zeroDiv, DivByZero} <= '0;
      {count, opB, aHold, acc, HI, LO} <= '0;
    end else if (state == IDLE && Start) begin
      isDiv <= Op[1];
      negRes <= !Op[0] && (A[31] ^ B[31]);
      negRem <= !Op[0] && A[31];
      zeroDiv <= Op[1] && B == 32'd0;
      DivByZero <= 1'b0;
      count <= '0;
      opB <= absB;
      aHold <= A;
      acc <= {32'd0, absA};
    end else if (state == IDLE) begin
      if (HiWrite) HI <= WriteData;
      if (LoWrite) LO <= WriteData;
    end else if (state == RUN) begin
      count <= count + 6'd1;
      acc <= isDiv ? {divDiff[32] ? divShift[31:0] : divDiff[31:0], acc[30:0], ~divDiff[32]}
                   : {mulSum, acc[31:1]};
    end else if (state == FIX) begin
      if (zeroDiv) begin
        HI <= aHold;
        LO <= 32'hFFFFFFFF;
        DivByZero <= 1'b1;
      end else if (isDiv) begin
        HI <= rem;
        LO <= quot;
      end else begin
        {HI, LO} <= prod;
      end
    end
  end
  assign Stall = !Reset && ((state == IDLE && Start) || state == RUN || state == FIX);
  assign Busy = state != IDLE;
  assign Done = state == DONE;
endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// tb_ex_muldiv_ctrl: directed vectors, scoreboard queue checked on each Done pulse.
module tb_ex_muldiv_ctrl;
  logic Clk = 0, Reset = 1, Start = 0, HiWrite = 0, LoWrite = 0;
  logic [1:0] Op = 0;
  logic [31:0] A = 0, B = 0, WriteData = 0;
  logic Stall, Busy, Done, DivByZero;
  logic [31:0] HI, LO;
  int checks = 0, passes = 0;
  logic [64:0] expQ[$];

  ex_muldiv_ctrl dut (.Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .HiWrite(HiWrite), .LoWrite(LoWrite), .WriteData(WriteData), .Stall(Stall),
    .Busy(Busy), .Done(Done), .DivByZero(DivByZero), .HI(HI), .LO(LO));

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passes++;
  endtask

  always @(negedge Clk) begin : monitor
    logic [64:0] e;
    if (Done) begin
      if (expQ.size() == 0) check("spuriousDone", Done, 0);
      else begin
        e = expQ.pop_front();
        check("HI", HI, e[64:33]);
        check("LO", LO, e[32:1]);
        check("DivByZero", DivByZero, e[0]);
      end
    end
  end

  // Issues one op, counts Stall cycles, optionally holds LoWrite through the op.
  task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] hi, input logic [31:0] lo, input logic dz,
                       input int stallExp, input logic lw);
    int n = 0;
    logic seenDead = 0;
    @(negedge Clk);
    Start = 1; Op = op; A = a; B = b; LoWrite = lw; WriteData = 32'hDEAD;
    expQ.push_back({hi, lo, dz});
    #1;
    while (Stall && n < 100) begin
      n++;
      @(negedge Clk);
      Start = 0; WriteData = 32'hBEEF;
      #1;
      if (LO == 32'hDEAD) seenDead = 1;
    end
    check("stallLen", n, stallExp);
    if (lw) check("deadNeverSeen", seenDead, 0);
    @(negedge Clk);
    LoWrite = 0;
  endtask

  initial begin
    repeat (2) @(negedge Clk);
    Reset = 0;
    #1 check("resetState", {Stall, Busy, Done, DivByZero, HI, LO}, 0);
    runOp(2'b00, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 0, 34, 0);
    runOp(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0, 34, 0);
    runOp(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 0, 34, 0);
    runOp(2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 34, 0);
    runOp(2'b11, 32'd7, 32'd2, 32'd1, 32'd3, 0, 34, 0);
    runOp(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 0, 34, 0);
    runOp(2'b11, 32'h1234, 32'd0, 32'h1234, 32'hFFFFFFFF, 1, 2, 0);
    #1 check("dbzHeld", {DivByZero, HI, LO}, {1'b1, 32'h1234, 32'hFFFFFFFF});
    runOp(2'b01, 32'd2, 32'd3, 32'd0, 32'd6, 0, 34, 0);
    // preload HI/LO, then reset mid-MULT
    HiWrite = 1; WriteData = 32'hAAAA;
    @(negedge Clk);
    HiWrite = 0; LoWrite = 1; WriteData = 32'h5555;
    @(negedge Clk);
    LoWrite = 0;
    #1 check("mthiMtlo", {HI, LO}, {32'hAAAA, 32'h5555});
    Start = 1; Op = 2'b00; A = 32'd3; B = 32'd4;
    @(negedge Clk);
    Start = 0;
    repeat (8) @(negedge Clk);
    #1 check("busyMidRun", {Busy, Stall}, 2'b11);
    @(negedge Clk);
    Reset = 1;
    #1 check("stallInReset", Stall, 0);
    @(negedge Clk);
    Reset = 0;
    #1 check("afterReset", {Stall, Busy, Done, DivByZero, HI, LO}, 0);
    runOp(2'b00, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 0, 34, 0);
    runOp(2'b01, 32'd4, 32'd5, 32'd0, 32'd20, 0, 34, 1);
    LoWrite = 1; WriteData = 32'hBEEF;
    @(negedge Clk);
    LoWrite = 0;
    #1 check("mtloIdle", LO, 32'hBEEF);
    repeat (3) @(negedge Clk);
    check("pendingExpected", expQ.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ex_muldiv_ctrl.md
# ex_muldiv_ctrl

Iterative multiply/divide sequencer for the EX stage. It accepts MULT/MULTU/DIV/DIVU issued from ID/EX and runs a shared 32-iteration shift-add / restoring-divide engine. While busy it holds the front of the pipeline with a stall. It owns the architectural HI/LO registers, including MTHI/MTLO writes and MFHI/MFLO reads.

## Interface
- No parameters; datapath width fixed at 32.
- Clk  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high
- Start  in  1  mult/div instruction present in EX
- Op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- A  in  32  rs operand (ReadData1 path)
- B  in  32  rt operand (ReadData2 path)
- HiWrite  in  1  MTHI
- LoWrite  in  1  MTLO
- WriteData  in  32  data for MTHI/MTLO
- Stall  out  1  freeze PC, IF/ID and ID/EX; insert bubble into EX/MEM
- Busy  out  1  engine not idle
- Done  out  1  one-cycle pulse, result committed
- DivByZero  out  1  last divide had B==0
- HI  out  32  HI register
- LO  out  32  LO register

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE + Start:
  - Latch Op.
  - Signed ops: latch |A| and |B|, and record result sign(s).
  - Clear the 6-bit iteration counter, 64-bit accumulator and remainder.
  - Next state is RUN.
  - Exception: DIV/DIVU with B==0 goes directly to FIX.
- RUN: one iteration per cycle; counter 0..31. On counter==31, go to FIX.
  - Multiply: if multiplier LSB is 1, add multiplicand into accumulator upper half; then shift right 1.
  - Divide: shift remainder:dividend left 1; trial subtract divisor; commit if non-negative and set quotient bit.
- FIX: apply sign correction, write HI/LO, go to DONE.
  - MULT: negate the 64-bit product if signs differ.
  - DIV: negate the quotient if signs differ; the remainder takes the dividend's sign.
  - MULT/MULTU: HI = product[63:32], LO = product[31:0].
  - DIV/DIVU: LO = quotient, HI = remainder.
  - Divide by zero: HI = A, LO = 0xFFFFFFFF, DivByZero = 1.
- DONE: Done=1, Stall=0; the instruction leaves EX at this edge. Next state is IDLE. Start is ignored in DONE.
- DivByZero: cleared on the next accepted Start; otherwise held.
- Signed arithmetic:
  - 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0 (two's-complement wrap, no trap).
  - Quotient truncates toward zero.
- HiWrite/LoWrite:
  - Honoured only in IDLE when Start=0; write HI/LO at the edge.
  - Start and a write in the same cycle: Start wins, the write is dropped.
  - Writes in any other state are dropped.
- Busy = (state != IDLE).

## Timing
- Stall is combinational: (state==IDLE & Start) | state==RUN | state==FIX. It is forced to 0 while Reset=1.
- Normal op, with cycle 0 = Start sampled in IDLE:
  - Stall high in cycles 0..33 (34 cycles).
  - RUN in cycles 1..32, FIX in cycle 33.
  - HI/LO update at the end of cycle 33 and are visible in cycle 34.
  - Done=1 in cycle 34; IDLE in cycle 35.
- Divide by zero: Stall high in cycles 0..1; HI/LO visible and Done=1 in cycle 2.
- Back-to-back ops: the next Start can be accepted in cycle 35 at the earliest. Throughput is one op per 35 cycles.
- MFHI/MFLO read HI/LO directly. Reads during Busy see old values (the reader is stalled anyway).
- Reset, at any state including mid-RUN:
  - At the edge: state = IDLE; HI, LO, counter and accumulators cleared.
  - All outputs (Stall, Busy, Done, DivByZero, HI, LO) are 0 from the next cycle.
  - The in-flight op is discarded, with no partial HI/LO write.

## Test plan
- MULT A=0xFFFFFFFE (−2), B=3 → HI=0xFFFFFFFF, LO=0xFFFFFFFA; Stall high exactly 34 cycles; Done pulse in cycle 34.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. MULT with the same operands → HI=0, LO=1.
- DIV A=0xFFFFFFF9 (−7), B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=2 → LO=3, HI=1. DIV A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU A=0x1234, B=0 → Stall 2 cycles, HI=0x1234, LO=0xFFFFFFFF, DivByZero=1. The following MULTU 2×3 clears DivByZero → LO=6.
- Reset asserted in cycle 10 of a MULT with prior HI/LO=0xAAAA/0x5555 → next cycle Stall=0, Busy=0, HI=LO=0, no Done pulse. A new Start the cycle after Reset deasserts completes normally.
- Same IDLE cycle Start (MULTU 4×5) and LoWrite 0xDEAD → LO=20 at Done, 0xDEAD never appears. LoWrite 0xBEEF while Busy is dropped. LoWrite 0xBEEF in IDLE with Start=0 → LO=0xBEEF next cycle.
